serial_tx_arbiter: RTL and testbench



---
 rtl/serial_tx_arbiter_if.sv | 35 +++
 rtl/serial_tx_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_arbiter_if.sv
// Bundle of requester and serial-line signals for serial_tx_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// whoever drives the byte requests and remote CTS (producers / testbench).
interface serial_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] data;
    logic [NUM_REQ-1:0]   ack;
    logic                 cts;
    logic                 tx;
    logic                 busy;
    logic [IDX_W-1:0]     grant_id;

    modport master (
        output req,
        output data,
        output cts,
        input  ack,
        input  tx,
        input  busy,
        input  grant_id
    );

    modport slave (
        input  req,
        input  data,
        input  cts,
        output ack,
        output tx,
        output busy,
        output grant_id
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin share of one UART transmit line among
// NUM_REQ byte sources. Frames are 8N1, LSB first, OVERSAMPLE clocks per bit.
// Optional even-parity bit between data and stop: define SERIAL_TX_ARB_PARITY_EN.
//
// Handshake: a requester raises req[i] with its byte on data[8*i+7:8*i] and
// holds both until ack[i] pulses for one cycle; the byte is captured on the
// granting edge, so data may change once ack is seen. Dropping req before ack
// withdraws the request. A grant only happens in IDLE while cts is high.
module serial_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int OVERSAMPLE = 32,
    parameter int IDX_W      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_tx_arbiter_if.slave   bus,
    output logic [2:0]           state_dbg_o
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam int REQ_EXT_W = 1 << IDX_W;

`ifdef SERIAL_TX_ARB_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [2:0]          bit_q, bit_d;
    logic [OS_W-1:0]     os_q, os_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    rr_last_q, rr_last_d;
`ifdef SERIAL_TX_ARB_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // Round-robin selection helpers
    logic [REQ_EXT_W-1:0] req_ext;
    logic [IDX_W:0]       cand_sum;
    logic [IDX_W-1:0]     cand;
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [7:0]           sel_byte;
    logic                 os_last;

    assign os_last = (os_q == OS_LAST);

    // Pick the first pending requester after rr_last, wrapping modulo NUM_REQ
    always_comb begin
        req_ext   = '0;
        req_ext[NUM_REQ-1:0] = bus.req;
        cand_sum  = '0;
        cand      = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_last_q} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!sel_found && req_ext[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Mux out the byte belonging to the selected requester
    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_byte = bus.data[8*i +: 8];
            end
        end
    end

    // Next-state and output logic for the frame FSM
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        os_d      = os_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ack_d     = '0;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
`ifdef SERIAL_TX_ARB_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                os_d   = '0;
                bit_d  = '0;
                // cts is only looked at here, so a frame in flight always completes
                if (bus.cts && sel_found) begin
                    shift_d   = sel_byte;
                    grant_d   = sel_idx;
                    rr_last_d = sel_idx;
                    ack_d     = NUM_REQ'(1) << sel_idx;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_START;
`ifdef SERIAL_TX_ARB_PARITY_EN
                    parity_d  = ^sel_byte;
`endif
                end
            end
            S_START: begin
                if (os_last) begin
                    os_d    = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    os_d = os_q + OS_W'(1);
                end
            end
            S_DATA: begin
                if (os_last) begin
                    os_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_ARB_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        // shift_q[0] already holds the next data bit
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    os_d = os_q + OS_W'(1);
                end
            end
`ifdef SERIAL_TX_ARB_PARITY_EN
            S_PARITY: begin
                if (os_last) begin
                    os_d    = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    os_d = os_q + OS_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (os_last) begin
                    os_d    = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    os_d = os_q + OS_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                os_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset forces the line idle and aborts any frame at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            os_q      <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            grant_q   <= '0;
            rr_last_q <= IDX_W'(NUM_REQ - 1);
`ifdef SERIAL_TX_ARB_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            os_q      <= os_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
`ifdef SERIAL_TX_ARB_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed testbench for serial_tx_arbiter (NUM_REQ=4, OVERSAMPLE=32).
module tb_serial_tx_arbiter;

    localparam int NR = 4;
    localparam int OS = 32;
    localparam int IW = 2;
`ifdef SERIAL_TX_ARB_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    serial_tx_arbiter_if #(.NUM_REQ(NR), .IDX_W(IW)) bus ();

    serial_tx_arbiter #(
        .NUM_REQ   (NR),
        .OVERSAMPLE(OS),
        .IDX_W     (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .state_dbg_o(state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance negedge by negedge until an ack shows up or the budget runs out
    task automatic wait_ack(input int max_cyc, output int waited);
        waited = 0;
        while (waited < max_cyc) begin
            @(negedge clk);
            waited++;
            if (bus.ack !== '0) break;
        end
    endtask

    // Called at the first negedge after the granting edge; walks the whole frame
    task automatic frame_watch(input string tag, input logic [7:0] b, input int drop_cts_at);
        int   good;
        int   busy_cnt;
        int   ack_cnt;
        int   cyc;
        logic expb;
        busy_cnt = 0;
        ack_cnt  = 0;
        cyc      = 0;
        for (int j = 0; j < NB; j++) begin
            if (j == 0)            expb = 1'b0;
            else if (j <= 8)       expb = b[j-1];
            else if (j == NB - 1)  expb = 1'b1;
            else                   expb = ^b;
            good = 0;
            for (int k = 0; k < OS; k++) begin
                if (cyc == drop_cts_at) bus.cts = 1'b0;
                if (bus.tx === expb) good++;
                if (bus.busy === 1'b1) busy_cnt++;
                if (bus.ack !== '0) ack_cnt++;
                cyc++;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, j), good, OS);
        end
        chk({tag, "_busy_cycles"}, busy_cnt, NB * OS);
        chk({tag, "_ack_cycles"}, ack_cnt, 1);
        chk({tag, "_idle_tx"}, {31'd0, bus.tx}, 1);
        chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 0);
    endtask

    initial begin
        int waited;
        int cnt_tx;
        int cnt_ack;
        int cnt_busy;
        int exp_id;

        reset    = 1'b1;
        bus.req  = '0;
        bus.data = '0;
        bus.cts  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_tx", {31'd0, bus.tx}, 1);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_ack", {28'd0, bus.ack}, 0);
        chk("rst_grant", {30'd0, bus.grant_id}, 0);
        chk("rst_state", {29'd0, state_dbg}, 0);
        reset = 1'b0;

        // Single byte A5 from requester 0
        bus.data[7:0] = 8'hA5;
        bus.req       = 4'b0001;
        bus.cts       = 1'b1;
        wait_ack(5, waited);
        chk("t1_wait", waited, 1);
        chk("t1_ack", {28'd0, bus.ack}, 32'h1);
        chk("t1_grant", {30'd0, bus.grant_id}, 0);
        bus.req = 4'b0000;
        frame_watch("t1", 8'hA5, -1);

        // All four requesting: order 0,1,2,3,0 from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        bus.data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req  = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_id = n % 4;
            wait_ack(5, waited);
            chk($sformatf("t2_wait%0d", n), waited, 1);
            chk($sformatf("t2_ack%0d", n), {28'd0, bus.ack}, 32'h1 << exp_id);
            chk($sformatf("t2_grant%0d", n), {30'd0, bus.grant_id}, exp_id);
            if (n == 4) bus.req = 4'b0000;
            frame_watch($sformatf("t2_f%0d", n), 8'h10 + 8'(exp_id), -1);
        end

        // Requester 2 pending with cts low: nothing may start
        bus.cts = 1'b0;
        bus.req = 4'b0100;
        cnt_tx  = 0;
        cnt_ack = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.tx === 1'b1) cnt_tx++;
            if (bus.ack === 4'b0000) cnt_ack++;
        end
        chk("t3_tx_idle", cnt_tx, 100);
        chk("t3_no_ack", cnt_ack, 100);
        bus.cts = 1'b1;
        wait_ack(5, waited);
        chk("t3_wait", waited, 1);
        chk("t3_ack", {28'd0, bus.ack}, 32'h4);
        chk("t3_grant", {30'd0, bus.grant_id}, 2);
        bus.req = 4'b0000;
        frame_watch("t3", 8'h12, -1);

        // cts dropped mid-frame: frame completes, next one waits for cts
        bus.data[7:0] = 8'h3C;
        bus.req       = 4'b0001;
        wait_ack(5, waited);
        chk("t4_wait", waited, 1);
        chk("t4_grant", {30'd0, bus.grant_id}, 0);
        frame_watch("t4", 8'h3C, 50);
        cnt_tx   = 0;
        cnt_ack  = 0;
        cnt_busy = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.tx === 1'b1) cnt_tx++;
            if (bus.ack === 4'b0000) cnt_ack++;
            if (bus.busy === 1'b0) cnt_busy++;
        end
        chk("t4_hold_tx", cnt_tx, 50);
        chk("t4_hold_ack", cnt_ack, 50);
        chk("t4_hold_busy", cnt_busy, 50);

        // Reset at cycle 150 of a frame
        bus.data[7:0] = 8'h07;
        bus.cts       = 1'b1;
        wait_ack(5, waited);
        chk("t5_wait", waited, 1);
        chk("t5_grant", {30'd0, bus.grant_id}, 0);
        bus.req = 4'b0000;
        repeat (150) @(negedge clk);
        chk("t5_mid_busy", {31'd0, bus.busy}, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_async_tx", {31'd0, bus.tx}, 1);
        chk("t5_async_busy", {31'd0, bus.busy}, 0);
        chk("t5_async_state", {29'd0, state_dbg}, 0);
        bus.data[15:8]  = 8'h5A;
        bus.data[31:24] = 8'hC3;
        bus.req         = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_ack(5, waited);
        chk("t5_rr_wait", waited, 1);
        chk("t5_rr_ack", {28'd0, bus.ack}, 32'h2);
        chk("t5_rr_grant", {30'd0, bus.grant_id}, 1);
        bus.req = 4'b1000;
        frame_watch("t5a", 8'h5A, -1);
        wait_ack(5, waited);
        chk("t5_next_wait", waited, 1);
        chk("t5_next_grant", {30'd0, bus.grant_id}, 3);
        bus.req = 4'b0000;
        frame_watch("t5b", 8'hC3, -1);

        // Byte 07: odd number of ones, parity bit 1 when parity is built in
        bus.data[7:0] = 8'h07;
        bus.req       = 4'b0001;
        wait_ack(5, waited);
        chk("t6_wait", waited, 1);
        chk("t6_grant", {30'd0, bus.grant_id}, 0);
        bus.req = 4'b0000;
        frame_watch("t6", 8'h07, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
